// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: issues one request at a time to instruction memory and
// delivers a registered instruction/PC pair to decode, with a one-entry skid buffer.
module instruction_fetch_stage #(
   parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] PC,
   input  logic        CLEAR_DECODING_STAGE,
   input  logic        STALL_DECODING_STAGE,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_GNT,
   input  logic        IMEM_RVALID,
   input  logic [31:0] IMEM_RDATA,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] PC_DECODING,
   output logic        VALID_DECODING,
   output logic        STALL_PROGRAME_COUNTER,
   output logic        FETCH_MISALIGNED
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_SKID} state_t;

   state_t      r_state;
   logic [31:0] r_inflight_pc;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;
   logic [31:0] r_instruction;
   logic [31:0] r_pc_decoding;
   logic        r_valid;
   logic        r_misaligned;

   logic w_aligned;
   logic w_rsp_in_wait;
   logic w_rsp_to_output;
   logic w_skid_release;

   assign w_aligned       = (PC[1:0] == 2'b00);
   assign w_rsp_in_wait   = (r_state == S_WAIT) && IMEM_RVALID;
   assign w_rsp_to_output = w_rsp_in_wait && (!r_valid || !STALL_DECODING_STAGE);
   assign w_skid_release  = (r_state == S_SKID) && !STALL_DECODING_STAGE;

   // The PC stage may only advance when a response is taken or a redirect happens.
   assign IMEM_REQ               = RST_N && (r_state == S_REQ) && w_aligned && !CLEAR_DECODING_STAGE;
   assign IMEM_ADDR              = PC;
   assign STALL_PROGRAME_COUNTER = !(RST_N && (CLEAR_DECODING_STAGE || w_rsp_in_wait));

   assign INSTRUCTION      = r_instruction;
   assign PC_DECODING      = r_pc_decoding;
   assign VALID_DECODING   = r_valid;
   assign FETCH_MISALIGNED = r_misaligned;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state       <= S_REQ;
         r_valid       <= 1'b0;
         r_instruction <= NOP_INSTRUCTION;
         r_pc_decoding <= 32'd0;
         r_misaligned  <= 1'b0;
         r_inflight_pc <= 32'd0;
      end else if (CLEAR_DECODING_STAGE) begin
         r_valid       <= 1'b0;
         r_instruction <= NOP_INSTRUCTION;
         r_misaligned  <= 1'b0;
         // A granted or still-outstanding request must have its response swallowed.
         if (((r_state == S_REQ) && IMEM_GNT) ||
             (((r_state == S_WAIT) || (r_state == S_DROP)) && !IMEM_RVALID))
            r_state <= S_DROP;
         else
            r_state <= S_REQ;
      end else begin
         if (w_rsp_to_output) begin
            r_valid       <= 1'b1;
            r_instruction <= IMEM_RDATA;
            r_pc_decoding <= r_inflight_pc;
         end else if (w_skid_release) begin
            r_valid       <= 1'b1;
            r_instruction <= r_skid_instr;
            r_pc_decoding <= r_skid_pc;
         end else if (!STALL_DECODING_STAGE) begin
            r_valid       <= 1'b0;
            r_instruction <= NOP_INSTRUCTION;
         end

         case (r_state)
            S_REQ: begin
               if (!w_aligned) begin
                  r_misaligned <= 1'b1;
               end else if (IMEM_GNT) begin
                  r_inflight_pc <= PC;
                  r_state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (IMEM_RVALID)
                  r_state <= w_rsp_to_output ? S_REQ : S_SKID;
            end
            S_DROP: begin
               if (IMEM_RVALID)
                  r_state <= S_REQ;
            end
            S_SKID: begin
               if (!STALL_DECODING_STAGE)
                  r_state <= S_REQ;
            end
         endcase
      end
   end

   // NOTE: skid data needs no reset; whether it holds anything is carried by r_state.
   always_ff @(posedge CLK) begin
      if (w_rsp_in_wait && !w_rsp_to_output && !CLEAR_DECODING_STAGE) begin
         r_skid_instr <= IMEM_RDATA;
         r_skid_pc    <= r_inflight_pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios followed by
// random traffic against a transaction-level reference model and a random-latency memory.
module tb_instruction_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        CLK;
   logic        RST_N;
   logic [31:0] PC;
   logic        CLEAR_DECODING_STAGE;
   logic        STALL_DECODING_STAGE;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_DECODING;
   logic        VALID_DECODING;
   logic        STALL_PROGRAME_COUNTER;
   logic        FETCH_MISALIGNED;

   instruction_fetch_stage #(.NOP_INSTRUCTION(NOP)) dut (
      .CLK                    (CLK),
      .RST_N                  (RST_N),
      .PC                     (PC),
      .CLEAR_DECODING_STAGE   (CLEAR_DECODING_STAGE),
      .STALL_DECODING_STAGE   (STALL_DECODING_STAGE),
      .IMEM_REQ               (IMEM_REQ),
      .IMEM_ADDR              (IMEM_ADDR),
      .IMEM_GNT               (IMEM_GNT),
      .IMEM_RVALID            (IMEM_RVALID),
      .IMEM_RDATA             (IMEM_RDATA),
      .INSTRUCTION            (INSTRUCTION),
      .PC_DECODING            (PC_DECODING),
      .VALID_DECODING         (VALID_DECODING),
      .STALL_PROGRAME_COUNTER (STALL_PROGRAME_COUNTER),
      .FETCH_MISALIGNED       (FETCH_MISALIGNED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: tracks the outstanding transaction, the buffered word and the
   // decode-side register in terms of fetched words, not fetch-stage states.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t      m_buf[$];
   logic        m_busy;
   logic        m_doomed;
   logic [31:0] m_inflight_pc;
   logic        m_out_valid;
   logic [31:0] m_out_instr;
   logic [31:0] m_out_pc;
   logic        m_mis;

   task automatic model_reset();
      m_buf.delete();
      m_busy        = 1'b0;
      m_doomed      = 1'b0;
      m_inflight_pc = 32'd0;
      m_out_valid   = 1'b0;
      m_out_instr   = NOP;
      m_out_pc      = 32'd0;
      m_mis         = 1'b0;
   endtask

   function automatic logic exp_req(input logic rst_n, input logic clr, input logic [31:0] pc);
      return rst_n && !m_busy && (m_buf.size() == 0) && (pc[1:0] == 2'b00) && !clr;
   endfunction

   task automatic model_update(input logic rst_n, input logic clr, input logic stl,
                               input logic [31:0] pc, input logic gnt, input logic rv,
                               input logic [31:0] rd);
      entry_t nw;
      logic   have_new;
      have_new = 1'b0;
      nw.instr = 32'd0;
      nw.pc    = 32'd0;
      if (!rst_n) begin
         model_reset();
      end else if (clr) begin
         if (m_busy && rv) begin
            m_busy   = 1'b0;
            m_doomed = 1'b0;
         end else if (m_busy) begin
            m_doomed = 1'b1;
         end else if ((m_buf.size() == 0) && gnt) begin
            m_busy   = 1'b1;
            m_doomed = 1'b1;
         end
         m_buf.delete();
         m_out_valid = 1'b0;
         m_out_instr = NOP;
         m_mis       = 1'b0;
      end else begin
         if (m_busy && rv) begin
            m_busy = 1'b0;
            if (m_doomed) begin
               m_doomed = 1'b0;
            end else begin
               nw.instr = rd;
               nw.pc    = m_inflight_pc;
               if (!m_out_valid || !stl) have_new = 1'b1;
               else                      m_buf.push_back(nw);
            end
         end else if (m_buf.size() != 0) begin
            if (!stl) begin
               nw       = m_buf.pop_front();
               have_new = 1'b1;
            end
         end else if (!m_busy) begin
            if (pc[1:0] != 2'b00) begin
               m_mis = 1'b1;
            end else if (gnt) begin
               m_busy        = 1'b1;
               m_inflight_pc = pc;
            end
         end
         if (have_new) begin
            m_out_valid = 1'b1;
            m_out_instr = nw.instr;
            m_out_pc    = nw.pc;
         end else if (!stl) begin
            m_out_valid = 1'b0;
            m_out_instr = NOP;
         end
      end
   endtask

   // One clock cycle: entered and left just after a falling edge.
   task automatic step(input logic rst_n, input logic clr, input logic stl,
                       input logic [31:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rd);
      logic e_req;
      logic e_stall;
      check("instruction", INSTRUCTION, m_out_instr);
      check("pc_decoding", PC_DECODING, m_out_pc);
      check("valid_decoding", {31'd0, VALID_DECODING}, {31'd0, m_out_valid});
      check("fetch_misaligned", {31'd0, FETCH_MISALIGNED}, {31'd0, m_mis});
      // NOTE: bench stimulus uses blocking assignments; DUT state updates only at posedge.
      RST_N                = rst_n;
      CLEAR_DECODING_STAGE = clr;
      STALL_DECODING_STAGE = stl;
      PC                   = pc;
      IMEM_GNT             = gnt;
      IMEM_RVALID          = rv;
      IMEM_RDATA           = rd;
      #1;
      e_req   = exp_req(rst_n, clr, pc);
      e_stall = !(rst_n && (clr || (m_busy && !m_doomed && rv)));
      check("imem_req", {31'd0, IMEM_REQ}, {31'd0, e_req});
      check("imem_addr", IMEM_ADDR, pc);
      check("stall_pc", {31'd0, STALL_PROGRAME_COUNTER}, {31'd0, e_stall});
      @(posedge CLK);
      model_update(rst_n, clr, stl, pc, gnt, rv, rd);
      @(negedge CLK);
   endtask

   logic        t_rst, t_clr, t_stl, t_gnt, t_rv;
   logic [31:0] t_pc, t_rd;
   logic        mem_pending;
   int          mem_cnt;

   initial begin
      RST_N = 1'b0; CLEAR_DECODING_STAGE = 1'b0; STALL_DECODING_STAGE = 1'b0;
      PC = 32'd0; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'd0;
      model_reset();
      mem_pending = 1'b0;
      mem_cnt     = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      // Minimum-latency fetch
      step(1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h104, 1'b0, 1'b1, 32'h00500093);
      check("lat_valid", {31'd0, VALID_DECODING}, 32'd1);
      check("lat_instr", INSTRUCTION, 32'h00500093);
      check("lat_pc", PC_DECODING, 32'h100);

      // Decode stalled while a second response arrives: skid path
      step(1'b1, 1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 1'b1, 32'h00A00113);
      step(1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 32'd0);
      check("skid_hold_instr", INSTRUCTION, 32'h00500093);
      check("skid_hold_pc", PC_DECODING, 32'h100);
      check("skid_hold_valid", {31'd0, VALID_DECODING}, 32'd1);
      check("skid_no_req", {31'd0, IMEM_REQ}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 1'b0, 32'd0);
      check("skid_out_instr", INSTRUCTION, 32'h00A00113);
      check("skid_out_pc", PC_DECODING, 32'h104);

      // Clear in WAIT; late response must be dropped
      step(1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 1'b1, 32'hDEADBEEF);
      check("drop_instr", INSTRUCTION, NOP);
      check("drop_valid", {31'd0, VALID_DECODING}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h304, 1'b0, 1'b1, 32'h11111111);
      check("redirect_instr", INSTRUCTION, 32'h11111111);
      check("redirect_pc", PC_DECODING, 32'h300);

      // Clear coinciding with the response
      step(1'b1, 1'b0, 1'b0, 32'h304, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h304, 1'b0, 1'b1, 32'h22222222);
      check("clr_rv_valid", {31'd0, VALID_DECODING}, 32'd0);
      check("clr_rv_instr", INSTRUCTION, NOP);
      step(1'b1, 1'b0, 1'b0, 32'h308, 1'b0, 1'b0, 32'd0);

      // Misaligned PC: sticky flag, cleared by redirect
      step(1'b1, 1'b0, 1'b0, 32'h102, 1'b0, 1'b0, 32'd0);
      check("mis_set", {31'd0, FETCH_MISALIGNED}, 32'd1);
      step(1'b1, 1'b0, 1'b0, 32'h308, 1'b0, 1'b0, 32'd0);
      check("mis_sticky", {31'd0, FETCH_MISALIGNED}, 32'd1);
      step(1'b1, 1'b1, 1'b0, 32'h308, 1'b0, 1'b0, 32'd0);
      check("mis_cleared", {31'd0, FETCH_MISALIGNED}, 32'd0);

      // Reset during WAIT
      step(1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h400, 1'b0, 1'b0, 32'd0);
      check("rst_valid", {31'd0, VALID_DECODING}, 32'd0);
      check("rst_instr", INSTRUCTION, NOP);
      check("rst_pc", PC_DECODING, 32'd0);
      check("rst_mis", {31'd0, FETCH_MISALIGNED}, 32'd0);
      check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
      check("rst_stall_pc", {31'd0, STALL_PROGRAME_COUNTER}, 32'd1);

      // Random traffic against a random-latency memory
      for (int i = 0; i < 3000; i++) begin
         t_rst = ($urandom_range(0, 99) != 0);
         t_clr = ($urandom_range(0, 9) == 0);
         t_stl = ($urandom_range(0, 2) == 0);
         t_pc  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) t_pc[1:0] = 2'($urandom_range(1, 3));
         t_gnt = exp_req(t_rst, t_clr, t_pc) && ($urandom_range(0, 3) != 0);
         t_rv  = t_rst && mem_pending && (mem_cnt == 0);
         t_rd  = $urandom;
         step(t_rst, t_clr, t_stl, t_pc, t_gnt, t_rv, t_rd);
         if (!t_rst) begin
            mem_pending = 1'b0;
         end else if (t_gnt) begin
            mem_pending = 1'b1;
            mem_cnt     = $urandom_range(0, 2);
         end else if (t_rv) begin
            mem_pending = 1'b0;
         end else if (mem_pending) begin
            mem_cnt--;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter NOP_INSTRUCTION, default 32'h00000013, meaning the word presented to decode during bubbles/flush.
REQ-002 CLK  input  1  sole clock, all state updates on posedge CLK.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 PC  input  32  fetch address from program counter stage.
REQ-005 CLEAR_DECODING_STAGE  input  1  flush from program counter stage (redirect).
REQ-006 STALL_DECODING_STAGE  input  1  decode cannot accept new instruction this cycle.
REQ-007 IMEM_REQ  output  1  instruction memory request.
REQ-008 IMEM_ADDR  output  32  request address.
REQ-009 IMEM_GNT  input  1  request accepted this cycle.
REQ-010 IMEM_RVALID  input  1  response valid; no backpressure.
REQ-011 IMEM_RDATA  input  32  response instruction word.
REQ-012 INSTRUCTION  output  32  registered instruction to decode.
REQ-013 PC_DECODING  output  32  registered PC of INSTRUCTION.
REQ-014 VALID_DECODING  output  1  INSTRUCTION/PC_DECODING valid.
REQ-015 STALL_PROGRAME_COUNTER  output  1  PC stage SHALL hold PC while high.
REQ-016 FETCH_MISALIGNED  output  1  sticky flag, PC[1:0] != 0 seen at issue.

Function
REQ-017 FSM states SHALL be REQ, WAIT, DROP, SKID; at most one outstanding memory request.
REQ-018 REQ: IMEM_REQ=1, IMEM_ADDR=PC when PC[1:0]==0 and CLEAR_DECODING_STAGE=0; else IMEM_REQ=0.
REQ-019 REQ with IMEM_GNT=1: capture PC into in-flight PC register, go WAIT.
REQ-020 REQ with PC[1:0]!=0: no request, FETCH_MISALIGNED<=1, remain REQ; flag cleared only by CLEAR_DECODING_STAGE or reset.
REQ-021 WAIT: IMEM_REQ=0; on IMEM_RVALID, response goes to output register if output empty or STALL_DECODING_STAGE=0 (go REQ), else into one-entry skid register (go SKID).
REQ-022 Minimum latency: GNT in cycle N, RVALID in N+1, VALID_DECODING=1 in N+2.
REQ-023 SKID: no request issued; when STALL_DECODING_STAGE=0, skid moves to output register, go REQ.
REQ-024 Output register with STALL_DECODING_STAGE=1 SHALL hold all three outputs unchanged.
REQ-025 Output register with STALL_DECODING_STAGE=0 and no new entry SHALL load VALID_DECODING=0, INSTRUCTION=NOP_INSTRUCTION, PC_DECODING unchanged.
REQ-026 STALL_PROGRAME_COUNTER SHALL be 0 only in cycles where a response is accepted in WAIT (RVALID=1) or CLEAR_DECODING_STAGE=1; 1 otherwise.
REQ-027 CLEAR_DECODING_STAGE=1 SHALL, next cycle: VALID_DECODING=0, INSTRUCTION=NOP_INSTRUCTION, skid emptied, FETCH_MISALIGNED=0; overrides STALL_DECODING_STAGE.
REQ-028 Clear in WAIT without RVALID, or clear in REQ coinciding with IMEM_GNT: go DROP.
REQ-029 Clear in WAIT with RVALID same cycle: response discarded, go REQ.
REQ-030 Clear in SKID or REQ (no GNT): go REQ.
REQ-031 DROP: IMEM_REQ=0; on IMEM_RVALID discard response, go REQ; a further clear stays DROP.
REQ-032 IMEM_RDATA SHALL never reach INSTRUCTION except via WAIT or SKID paths above.

Reset
REQ-033 RST_N=0 at posedge: state REQ, VALID_DECODING=0, INSTRUCTION=NOP_INSTRUCTION, PC_DECODING=0, skid empty, FETCH_MISALIGNED=0.
REQ-034 IMEM_REQ SHALL be 0 while RST_N=0; STALL_PROGRAME_COUNTER=1 while RST_N=0.
REQ-035 Reset mid-WAIT/DROP/SKID abandons the transaction; instruction memory shares RST_N, so no stale response follows.

Verification
REQ-036 PC=0x100, GNT cycle 1, RVALID cycle 2 RDATA=0x00500093 -> cycle 3 VALID_DECODING=1, INSTRUCTION=0x00500093, PC_DECODING=0x100; STALL_PROGRAME_COUNTER=0 in cycle 2 only.
REQ-037 Output valid, STALL_DECODING_STAGE=1 for 3 cycles, RVALID arrives -> outputs held, state SKID, no IMEM_REQ; stall drops -> skid word appears next cycle.
REQ-038 Clear in WAIT, RVALID 2 cycles later RDATA=0xDEADBEEF -> 0xDEADBEEF never on INSTRUCTION, VALID_DECODING=0, next request uses new PC.
REQ-039 Clear and RVALID same cycle -> response dropped, state REQ next cycle, VALID_DECODING=0.
REQ-040 PC=0x102 -> IMEM_REQ=0, FETCH_MISALIGNED=1 next cycle and sticky; clear -> flag 0.
REQ-041 RST_N=0 during WAIT -> next cycle all outputs at REQ-033 values, IMEM_REQ=0.
